// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch engine with prefetch FIFO feeding IF/ID
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     fetch_pc, fetch_pc_nxt;
    logic [31:0]     addr_nxt;
    logic            req_nxt;
    logic [31:0]     target_pc;

    logic [31:0]     fifo_inst [DEPTH];
    logic [31:0]     fifo_pc   [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     cnt, cnt_nxt, cnt_if_ack;
    logic            push, pop, flush;

    assign target_pc  = redirect_pc & ~32'h3;
    assign inst_valid = (cnt != '0);
    assign pop        = inst_valid && !stall && !redirect;
    // Occupancy the FIFO would have if this cycle's ack is pushed; decides whether to keep streaming.
    assign cnt_if_ack = cnt + (AW+1)'(1) - (AW+1)'(pop);
    assign cnt_nxt    = cnt + (AW+1)'(push) - (AW+1)'(pop);

    assign inst    = inst_valid ? fifo_inst[rd_ptr] : NOP_WORD;
    assign inst_pc = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign count   = cnt;

    always_comb begin
        state_nxt    = state;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        flush        = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = target_pc;
                end else if (cnt != DEPTH_C) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = target_pc;
                    if (imem_ack) begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = imem_addr + 32'd4;
                    if (cnt_if_ack < DEPTH_C) begin
                        addr_nxt = imem_addr + 32'd4;
                    end else begin
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                // The wrong-path request must still complete; only its data is thrown away.
                if (redirect) fetch_pc_nxt = target_pc;
                if (imem_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            fetch_pc  <= fetch_pc_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= imem_addr;
        end
    end
endmodule
